counter_timer_arbiter: RTL and testbench



---
 rtl/counter_arb_pkg.sv | 36 +++
 rtl/countermod_en.sv | 37 +++
 rtl/counter_timer_arbiter.sv | 117 +++++++++++
 tb/tb_counter_timer_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_arb_pkg.sv
// Shared types and helpers for the counter timer arbiter: FSM encoding,
// request-length clamping and the round-robin pick.
package counter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // A zero-length request still needs one tick; lengths beyond the modulus saturate.
    function automatic int clamp_len(input int len, input int modulus);
        if (len == 0) begin
            return 1;
        end
        if (len > modulus) begin
            return modulus;
        end
        return len;
    endfunction

    // Scans from ptr upward with wrap; the lowest offset from ptr wins.
    function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
        int pick;
        int idx;
        pick = ptr;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (ptr + k) % n;
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/countermod_en.sv
// Modulo-MOD up counter with synchronous clear (priority) and advance enable.
module countermod_en
    import counter_arb_pkg::*;
#(
    parameter int MOD = 7,
    parameter int CW  = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] value
);

    logic [CW-1:0] value_q;
    logic [CW-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (en) begin
            value_d = (value_q == CW'(MOD - 1)) ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/counter_timer_arbiter.sv
// Round-robin arbiter lending one modulo counter to NREQ requesters as a
// tick timer; pulses done to the owner when its programmed count completes.
module counter_timer_arbiter
    import counter_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int MOD  = 7,
    parameter int CW   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [CW-1:0]      value,
    output arb_state_t         state_dbg
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   len_q, len_d;

    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   next_ptr;
    logic [CW-1:0]   cnt_value;
    logic            cnt_clear;
    logic            complete;
    logic            abort;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        cnt_clear = 1'b1;
        complete  = 1'b0;
        abort     = 1'b0;
        pick_idx  = IW'(rr_pick(32'(req), int'(ptr_q), NREQ));
        next_ptr  = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d           = RUN;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    len_d             = CW'(clamp_len(int'(len[pick_idx*CW +: CW]), MOD));
                end
            end
            RUN: begin
                // Owner dropping its request beats a completion in the same cycle.
                abort     = !req[owner_q];
                complete  = tick && (cnt_value == len_q - 1'b1);
                cnt_clear = abort || complete;
                if (abort) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end else if (complete) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = next_ptr;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
        end
    end

    countermod_en #(
        .MOD (MOD),
        .CW  (CW)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .en    (tick),
        .value (cnt_value)
    );

    assign grant     = grant_q;
    assign done      = (state_q == DONE) ? grant_q : '0;
    assign busy      = (state_q == RUN);
    assign value     = busy ? cnt_value : '0;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Bench for counter_timer_arbiter: vector table for single-owner timing,
// hand sequences for reset, round-robin, wrap and abort corner cases.
module tb_counter_timer_arbiter;
    import counter_arb_pkg::*;

    logic       clock;
    logic       reset;
    logic       tick;
    logic [1:0] req;
    logic [5:0] len;
    logic [1:0] grant;
    logic [1:0] done;
    logic       busy;
    logic [2:0] value;
    arb_state_t state_dbg;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];

    typedef struct {
        logic [1:0] req;
        logic [5:0] len;
        logic       tick;
        logic [1:0] exp_grant;
        logic [1:0] exp_done;
        logic       exp_busy;
        logic [2:0] exp_value;
    } vec_t;

    vec_t vecs[17];

    counter_timer_arbiter #(
        .NREQ (2),
        .MOD  (7),
        .CW   (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .req       (req),
        .len       (len),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .value     (value),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_grant"}, 32'(grant), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_value"}, 32'(value), 32'd0);
    endtask

    task automatic drive(input logic [1:0] r, input logic [5:0] l, input logic t);
        req  = r;
        len  = l;
        tick = t;
    endtask

    initial begin
        int budget;
        logic [1:0] exp_done;

        // {req, {len1,len0}, tick} -> {grant, done, busy, value} after the next edge
        vecs[0]  = '{2'b01, 6'd3, 1'b1, 2'b01, 2'b00, 1'b1, 3'd0};
        vecs[1]  = '{2'b01, 6'd3, 1'b1, 2'b01, 2'b00, 1'b1, 3'd1};
        vecs[2]  = '{2'b01, 6'd3, 1'b1, 2'b01, 2'b00, 1'b1, 3'd2};
        vecs[3]  = '{2'b01, 6'd3, 1'b1, 2'b01, 2'b01, 1'b0, 3'd0};
        vecs[4]  = '{2'b00, 6'd3, 1'b1, 2'b00, 2'b00, 1'b0, 3'd0};
        vecs[5]  = '{2'b01, 6'd4, 1'b0, 2'b01, 2'b00, 1'b1, 3'd0};
        vecs[6]  = '{2'b01, 6'd4, 1'b1, 2'b01, 2'b00, 1'b1, 3'd1};
        vecs[7]  = '{2'b01, 6'd4, 1'b0, 2'b01, 2'b00, 1'b1, 3'd1};
        vecs[8]  = '{2'b01, 6'd4, 1'b1, 2'b01, 2'b00, 1'b1, 3'd2};
        vecs[9]  = '{2'b01, 6'd4, 1'b0, 2'b01, 2'b00, 1'b1, 3'd2};
        vecs[10] = '{2'b01, 6'd4, 1'b1, 2'b01, 2'b00, 1'b1, 3'd3};
        vecs[11] = '{2'b01, 6'd4, 1'b0, 2'b01, 2'b00, 1'b1, 3'd3};
        vecs[12] = '{2'b01, 6'd4, 1'b1, 2'b01, 2'b01, 1'b0, 3'd0};
        vecs[13] = '{2'b00, 6'd4, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0};
        vecs[14] = '{2'b01, 6'd0, 1'b1, 2'b01, 2'b00, 1'b1, 3'd0};
        vecs[15] = '{2'b01, 6'd0, 1'b1, 2'b01, 2'b01, 1'b0, 3'd0};
        vecs[16] = '{2'b00, 6'd0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0};

        reset = 1'b0;
        drive(2'b00, 6'd0, 1'b0);
        #2;
        chk_idle("por");
        chk("por_state", 32'(state_dbg), 32'(IDLE));
        #10 reset = 1'b1;
        step();
        chk_idle("post_reset");

        // single request, tick gating, zero-length clamp
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].req, vecs[i].len, vecs[i].tick);
            step();
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_value", i), 32'(value), 32'(vecs[i].exp_value));
        end

        // asynchronous reset in the middle of a run
        drive(2'b01, 6'd5, 1'b1);
        step();
        step();
        chk("pre_reset_value", 32'(value), 32'd1);
        #3 reset = 1'b0;
        #1;
        chk_idle("async_reset");
        chk("async_reset_state", 32'(state_dbg), 32'(IDLE));
        drive(2'b00, 6'd0, 1'b0);
        step();
        chk_idle("reset_held");
        #3 reset = 1'b1;
        step();
        chk_idle("reset_released");

        // round-robin with both requests held
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        drive(2'b11, {3'd2, 3'd2}, 1'b1);
        step();
        chk("rr_first_grant", 32'(grant), 32'b01);
        budget = 60;
        while (exp_q.size() > 0 && budget > 0) begin
            if (done != 2'b00) begin
                exp_done = exp_q.pop_front();
                chk("rr_done", 32'(done), 32'(exp_done));
                chk("rr_done_grant", 32'(grant), 32'(done));
            end
            if (exp_q.size() > 0) begin
                step();
                budget--;
                chk("rr_value_range", 32'(value < 3'd7), 32'd1);
                chk("rr_grant_onehot0", 32'($onehot0(grant)), 32'd1);
            end
        end
        chk("rr_pending", 32'(exp_q.size()), 32'd0);
        drive(2'b00, 6'd0, 1'b1);
        step();
        chk_idle("rr_end");

        // len = MOD runs the full cycle and finishes on the wrap tick
        drive(2'b01, 6'd7, 1'b1);
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("wrap_value%0d", k), 32'(value), 32'(k));
            chk($sformatf("wrap_busy%0d", k), 32'(busy), 32'd1);
        end
        step();
        chk("wrap_done", 32'(done), 32'b01);
        chk("wrap_done_value", 32'(value), 32'd0);
        drive(2'b00, 6'd0, 1'b1);
        step();
        chk_idle("wrap_end");

        // abort by the owner hands the counter to the pending requester
        drive(2'b01, {3'd2, 3'd5}, 1'b1);
        step();
        chk("abort_grant0", 32'(grant), 32'b01);
        req = 2'b11;
        step();
        chk("abort_ignore_req1", 32'(grant), 32'b01);
        step();
        chk("abort_value2", 32'(value), 32'd2);
        req = 2'b10;
        step();
        chk_idle("abort");
        step();
        chk("abort_next_grant", 32'(grant), 32'b10);
        chk("abort_next_busy", 32'(busy), 32'd1);
        chk("abort_next_value", 32'(value), 32'd0);
        drive(2'b00, 6'd0, 1'b0);
        step();
        chk_idle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
